ahb2apb_bridge: RTL and testbench

//   AHB slave to APB master bridge. Sits directly downstream of the AHB smart-connect on one

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/ahb2apb_bridge.sv | 141 ++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB protocol constants and byte-lane helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Byte strobes for a 32-bit lane given transfer size and low address bits.
  function automatic logic [3:0] ahb_strb(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] strb;
    strb = '0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = '0;
    endcase
    return strb;
  endfunction

  // Oversized or misaligned transfers cannot be mapped onto a 32-bit APB access.
  function automatic logic ahb_illegal(input logic [2:0] hsize, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (hsize)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr[0];
      HSIZE_WORD: bad = |addr;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB single-transfer slave to APB master bridge, one transfer in flight.
module ahb2apb_bridge
  import ahb_pkg::*;
#(
  parameter int C_S_AHB_DATA_WIDTH = 32,
  parameter int C_S_AHB_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          HCLK,
  input  logic                          H_nREST,
  input  logic                          HSEL,
  input  logic [C_S_AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  logic [C_S_AHB_DATA_WIDTH-1:0] HWDATA,
  output logic [C_S_AHB_DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]                    HRESP,
  output logic                          HREAD_o,
  output logic [APB_ADDR_WIDTH-1:0]     PADDR,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [C_S_AHB_DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]                    PSTRB,
  input  logic [C_S_AHB_DATA_WIDTH-1:0] PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic          illegal;
  logic          timeout_hit;
  logic [1:0]    addr_lo_q;
  logic [2:0]    hsize_q;
  logic [CW-1:0] tcnt_q;

  // Address-phase qualification and timeout threshold decode.
  always_comb begin
    accept      = HSEL & HTRANS[1] & HREAD_o;
    illegal     = ahb_illegal(HSIZE, HADDR[1:0]);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state logic; DONE and ERR2 double as address phases for the next transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          if (illegal)     state_d = ST_ERR1;
          else if (HWRITE) state_d = ST_WLATCH;
          else             state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WLATCH: state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)           state_d = PSLVERR ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge H_nREST) begin
    if (!H_nREST) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Handshake outputs registered from the next state so they align with it.
  always_ff @(posedge HCLK or negedge H_nREST) begin
    if (!H_nREST) begin
      HREAD_o <= 1'b1;
      HRESP   <= HRESP_OKAY;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      HREAD_o <= (state_d inside {ST_IDLE, ST_DONE, ST_ERR2});
      HRESP   <= (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
      PSEL    <= (state_d inside {ST_SETUP, ST_ACCESS});
      PENABLE <= (state_d == ST_ACCESS);
    end
  end

  // APB request fields: address/direction on accept, write data and strobes one cycle later.
  always_ff @(posedge HCLK or negedge H_nREST) begin
    if (!H_nREST) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      addr_lo_q <= '0;
      hsize_q   <= '0;
    end else begin
      if (accept && !illegal) begin
        PADDR     <= HADDR[APB_ADDR_WIDTH-1:0];
        PWRITE    <= HWRITE;
        addr_lo_q <= HADDR[1:0];
        hsize_q   <= HSIZE;
        if (!HWRITE) PSTRB <= '0;
      end
      if (state_q == ST_WLATCH) begin
        PWDATA <= HWDATA;
        PSTRB  <= ahb_strb(hsize_q, addr_lo_q);
      end
    end
  end

  // Read data capture on a successful read completion only.
  always_ff @(posedge HCLK or negedge H_nREST) begin
    if (!H_nREST) HRDATA <= '0;
    else if (state_q == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
  end

  // Wait-state counter: advances each stalled ACCESS cycle, cleared on leaving ACCESS.
  always_ff @(posedge HCLK or negedge H_nREST) begin
    if (!H_nREST) tcnt_q <= '0;
    else if (state_q == ST_ACCESS && state_d == ST_ACCESS) tcnt_q <= tcnt_q + 1'b1;
    else tcnt_q <= '0;
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge.
module tb_ahb2apb_bridge;

  logic        HCLK = 1'b0;
  logic        H_nREST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREAD_o;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  ahb2apb_bridge #(
    .C_S_AHB_DATA_WIDTH(32),
    .C_S_AHB_ADDR_WIDTH(32),
    .APB_ADDR_WIDTH(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .H_nREST(H_nREST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
    .HREAD_o(HREAD_o), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic psel_e, input logic pen_e,
                         input logic hr_e, input logic [1:0] resp_e);
    chk({tag, ".PSEL"},    {31'd0, PSEL},    {31'd0, psel_e});
    chk({tag, ".PENABLE"}, {31'd0, PENABLE}, {31'd0, pen_e});
    chk({tag, ".HREAD_o"}, {31'd0, HREAD_o}, {31'd0, hr_e});
    chk({tag, ".HRESP"},   {30'd0, HRESP},   {30'd0, resp_e});
  endtask

  task automatic addr_phase(input logic [1:0] trans, input logic wr,
                            input logic [2:0] size, input logic [31:0] addr);
    HSEL = 1'b1; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = '0;
  endtask

  initial begin
    H_nREST = 1'b0;
    bus_idle();
    HWDATA = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick(); tick();

    // Reset values
    chk_ctl("rst", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("rst.HRDATA", HRDATA, 32'h0);
    chk("rst.PADDR", {16'd0, PADDR}, 32'h0);
    chk("rst.PWDATA", PWDATA, 32'h0);
    chk("rst.PSTRB", {28'd0, PSTRB}, 32'h0);
    chk("rst.PWRITE", {31'd0, PWRITE}, 32'h0);
    H_nREST = 1'b1;
    tick();

    // Selected BUSY transfer: zero-wait OKAY, no APB activity
    addr_phase(2'b01, 1'b0, 3'b010, 32'h0000_0010);
    tick();
    chk_ctl("busy", 1'b0, 1'b0, 1'b1, 2'b00);
    bus_idle();

    // Word read 0x0010, PREADY=1
    PRDATA = 32'hDEAD_BEEF; PREADY = 1'b1;
    addr_phase(2'b10, 1'b0, 3'b010, 32'h0000_0010);
    tick(); bus_idle();
    chk_ctl("rd.setup", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("rd.PADDR", {16'd0, PADDR}, 32'h0000_0010);
    chk("rd.PWRITE", {31'd0, PWRITE}, 32'h0);
    chk("rd.PSTRB", {28'd0, PSTRB}, 32'h0);
    tick();
    chk_ctl("rd.access", 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    chk_ctl("rd.done", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("rd.HRDATA", HRDATA, 32'hDEAD_BEEF);
    tick();
    chk_ctl("rd.idle", 1'b0, 1'b0, 1'b1, 2'b00);

    // Byte write 0x0003 with three wait states
    PREADY = 1'b0; PRDATA = 32'h0BAD_0BAD;
    addr_phase(2'b10, 1'b1, 3'b000, 32'h0000_0003);
    tick(); bus_idle();
    HWDATA = 32'h5A00_0000;
    chk_ctl("bw.wlatch", 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    HWDATA = 32'hFFFF_FFFF;
    chk_ctl("bw.setup", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("bw.PADDR", {16'd0, PADDR}, 32'h0000_0003);
    chk("bw.PWDATA", PWDATA, 32'h5A00_0000);
    chk("bw.PSTRB", {28'd0, PSTRB}, 32'h0000_0008);
    chk("bw.PWRITE", {31'd0, PWRITE}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_ctl("bw.wait", 1'b1, 1'b1, 1'b0, 2'b00);
      chk("bw.wait.PWDATA", PWDATA, 32'h5A00_0000);
      tick();
    end
    PREADY = 1'b1;
    chk_ctl("bw.last", 1'b1, 1'b1, 1'b0, 2'b00);
    chk("bw.last.PSTRB", {28'd0, PSTRB}, 32'h0000_0008);
    tick();
    chk_ctl("bw.done", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("bw.HRDATA", HRDATA, 32'hDEAD_BEEF);
    tick();

    // Misaligned word read 0x0002 -> two-cycle ERROR, no APB cycle
    addr_phase(2'b10, 1'b0, 3'b010, 32'h0000_0002);
    tick(); bus_idle();
    chk_ctl("mis.err1", 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk_ctl("mis.err2", 1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    chk_ctl("mis.idle", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("mis.HRDATA", HRDATA, 32'hDEAD_BEEF);

    // Oversized transfer (HSIZE=3) -> ERROR
    addr_phase(2'b10, 1'b1, 3'b011, 32'h0000_0000);
    tick(); bus_idle();
    chk_ctl("big.err1", 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk_ctl("big.err2", 1'b0, 1'b0, 1'b1, 2'b01);
    tick();

    // Half write 0x0006 with PSLVERR, then a read accepted in ERR2
    PREADY = 1'b1; PSLVERR = 1'b1;
    addr_phase(2'b10, 1'b1, 3'b001, 32'h0000_0006);
    tick(); bus_idle();
    HWDATA = 32'h1234_5678;
    tick();
    chk_ctl("sle.setup", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("sle.PSTRB", {28'd0, PSTRB}, 32'h0000_000C);
    chk("sle.PWDATA", PWDATA, 32'h1234_5678);
    tick();
    chk_ctl("sle.access", 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    chk_ctl("sle.err1", 1'b0, 1'b0, 1'b0, 2'b01);
    PSLVERR = 1'b0; PRDATA = 32'hCAFE_F00D;
    addr_phase(2'b10, 1'b0, 3'b010, 32'h0000_0020);
    tick();
    chk_ctl("sle.err2", 1'b0, 1'b0, 1'b1, 2'b01);
    tick(); bus_idle();
    chk_ctl("sle.next.setup", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("sle.next.PADDR", {16'd0, PADDR}, 32'h0000_0020);
    chk("sle.next.PSTRB", {28'd0, PSTRB}, 32'h0);
    tick();
    tick();
    chk_ctl("sle.next.done", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("sle.next.HRDATA", HRDATA, 32'hCAFE_F00D);
    tick();

    // Back-to-back reads, second accepted in DONE
    PRDATA = 32'h1111_1111;
    addr_phase(2'b10, 1'b0, 3'b010, 32'h0000_0030);
    tick(); bus_idle();
    tick();
    tick();
    chk_ctl("b2b.done1", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("b2b.HRDATA1", HRDATA, 32'h1111_1111);
    PRDATA = 32'h2222_2222;
    addr_phase(2'b11, 1'b0, 3'b010, 32'h0000_0034);
    tick(); bus_idle();
    chk_ctl("b2b.setup2", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("b2b.PADDR2", {16'd0, PADDR}, 32'h0000_0034);
    tick();
    tick();
    chk_ctl("b2b.done2", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("b2b.HRDATA2", HRDATA, 32'h2222_2222);
    tick();

    // Timeout: PREADY stuck low, abort after 8 ACCESS cycles
    PREADY = 1'b0;
    addr_phase(2'b10, 1'b1, 3'b010, 32'h0000_0040);
    tick(); bus_idle();
    HWDATA = 32'hA5A5_A5A5;
    tick();
    chk("to.PSTRB", {28'd0, PSTRB}, 32'h0000_000F);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_ctl("to.access", 1'b1, 1'b1, 1'b0, 2'b00);
      tick();
    end
    chk_ctl("to.err1", 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk_ctl("to.err2", 1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    chk_ctl("to.idle", 1'b0, 1'b0, 1'b1, 2'b00);
    chk("to.HRDATA", HRDATA, 32'h2222_2222);

    // Reset asserted during ACCESS drops PSEL/PENABLE at once
    PREADY = 1'b0;
    addr_phase(2'b10, 1'b0, 3'b010, 32'h0000_0050);
    tick(); bus_idle();
    tick();
    chk_ctl("ra.access", 1'b1, 1'b1, 1'b0, 2'b00);
    #2 H_nREST = 1'b0;
    #1;
    chk("ra.PSEL", {31'd0, PSEL}, 32'h0);
    chk("ra.PENABLE", {31'd0, PENABLE}, 32'h0);
    chk("ra.HRDATA", HRDATA, 32'h0);
    tick(); tick();
    H_nREST = 1'b1;
    PREADY = 1'b1;
    tick();
    chk_ctl("ra.idle", 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    chk_ctl("ra.idle2", 1'b0, 1'b0, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
